// File: rtl/spiker_adapter_pkg.sv
// rtl/spiker_adapter_pkg.sv - shared types and sizing helpers for the spiker adapter
package spiker_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } packer_state_e;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int n_words(input int n_spikes, input int width);
        return (n_spikes + width - 1) / width;
    endfunction

    function automatic int bpw(input int width, input int in_w);
        return width / in_w;
    endfunction

    function automatic int n_beats(input int n_spikes, input int in_w);
        return (n_spikes + in_w - 1) / in_w;
    endfunction

    // Register-array index width; a single-word frame still needs one bit.
    function automatic int idx_w(input int n_spikes, input int width);
        return clog2_min1(n_words(n_spikes, width));
    endfunction

    function automatic int cnt_w(input int n_spikes);
        return $clog2(n_spikes + 1);
    endfunction

endpackage

// File: rtl/spiker_popcount.sv
// rtl/spiker_popcount.sv - combinational population count of one spike beat
module spiker_popcount #(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/spiker_result_packer.sv
// rtl/spiker_result_packer.sv - packs the core's spike stream into result register words
module spiker_result_packer
    import spiker_adapter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    parameter int IN_W     = 8,
    localparam int IDX_W   = idx_w(N_SPIKES, WIDTH),
    localparam int CNT_W   = cnt_w(N_SPIKES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_mode_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             spike_valid_i,
    input  logic [IN_W-1:0]  spike_i,
    output logic             spike_ready_o,
    output logic [WIDTH-1:0] result_d_o,
    output logic [IDX_W-1:0] result_idx_o,
    output logic             result_de_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] spike_count_o
);

    localparam int N_WORDS = n_words(N_SPIKES, WIDTH);
    localparam int BPW     = bpw(WIDTH, IN_W);
    localparam int N_BEATS = n_beats(N_SPIKES, IN_W);
    localparam int BIW_W   = clog2_min1(BPW);
    localparam int BT_W    = clog2_min1(N_BEATS);
    localparam int PCW     = $clog2(IN_W + 1);

    if ((IN_W < 1) || (IN_W > WIDTH) || ((WIDTH % IN_W) != 0)) begin : g_param_check
        $error("spiker_result_packer: IN_W must be in 1..WIDTH and divide WIDTH");
    end

    packer_state_e     state_q, state_d;
    logic [WIDTH-1:0]  word_buf_q;
    logic [WIDTH-1:0]  word_buf_ins;
    logic [BIW_W-1:0]  biw_q;
    logic [BT_W-1:0]   bt_q;
    logic [IDX_W-1:0]  word_q;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  d_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IN_W-1:0]   masked;
    logic [PCW-1:0]    pop;
    logic [CNT_W:0]    sum;
    logic              take;
    logic              closing;
    logic              last_word;
    logic              unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Spikes past the end of the frame never reach the buffer or the count.
    always_comb begin
        masked = spike_i;
        for (int i = 0; i < IN_W; i++) begin
            if (int'(bt_q) * IN_W + i >= N_SPIKES) begin
                masked[i] = 1'b0;
            end
        end
    end

    spiker_popcount #(.W(IN_W)) u_popcount (
        .bits  (masked),
        .count (pop)
    );

    always_comb begin
        word_buf_ins = word_buf_q;
        word_buf_ins[int'(biw_q) * IN_W +: IN_W] = masked;
    end

    // Abort wins over a same-cycle accept, so the beat is neither buffered nor counted.
    assign take      = (state_q == COLLECT) && spike_valid_i && !abort_i;
    assign closing   = (biw_q == BIW_W'(BPW - 1)) || (bt_q == BT_W'(N_BEATS - 1));
    assign last_word = (word_q == IDX_W'(N_WORDS - 1));
    assign sum       = {1'b0, count_q} + (CNT_W + 1)'(pop);

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) state_d = COLLECT;
                COLLECT:    if (take && closing) state_d = WRITE;
                WRITE:      state_d = last_word ? DONE : COLLECT;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_buf_q <= '0;
            biw_q      <= '0;
            bt_q       <= '0;
            word_q     <= '0;
            count_q    <= '0;
            d_q        <= '0;
            idx_q      <= '0;
        end else if (!abort_i) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        word_buf_q <= '0;
                        biw_q      <= '0;
                        bt_q       <= '0;
                        word_q     <= '0;
                        count_q    <= '0;
                    end
                end
                COLLECT: begin
                    if (take) begin
                        word_buf_q <= word_buf_ins;
                        biw_q      <= closing ? '0 : biw_q + BIW_W'(1);
                        bt_q       <= bt_q + BT_W'(1);
                        if (sum > (CNT_W + 1)'(N_SPIKES)) begin
                            count_q <= CNT_W'(N_SPIKES);
                        end else begin
                            count_q <= sum[CNT_W-1:0];
                        end
                        // Result registers load here so the word is stable for the strobe and after it.
                        if (closing) begin
                            d_q   <= word_buf_ins;
                            idx_q <= word_q;
                        end
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_q     <= word_q + IDX_W'(1);
                        word_buf_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spike_ready_o = (state_q == COLLECT);
    assign result_de_o   = (state_q == WRITE);
    assign busy_o        = (state_q == COLLECT) || (state_q == WRITE);
    assign done_o        = (state_q == DONE);
    assign result_d_o    = d_q;
    assign result_idx_o  = idx_q;
    assign spike_count_o = count_q;

endmodule

// File: tb/tb_spiker_result_packer.sv
// tb/tb_spiker_result_packer.sv - directed bench for spiker_result_packer
module tb_spiker_result_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic test_mode = 1'b0;

    logic        a_start = 0, a_abort = 0, a_valid = 0;
    logic [7:0]  a_spike = '0;
    logic        a_ready, a_de, a_busy, a_done;
    logic [31:0] a_d;
    logic [4:0]  a_idx;
    logic [9:0]  a_count;

    logic        b_start = 0, b_abort = 0, b_valid = 0;
    logic [3:0]  b_spike = '0;
    logic        b_ready, b_de, b_busy, b_done;
    logic [15:0] b_d;
    logic [1:0]  b_idx;
    logic [5:0]  b_count;

    spiker_result_packer #(.WIDTH(32), .N_SPIKES(784), .IN_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
        .start_i(a_start), .abort_i(a_abort),
        .spike_valid_i(a_valid), .spike_i(a_spike), .spike_ready_o(a_ready),
        .result_d_o(a_d), .result_idx_o(a_idx), .result_de_o(a_de),
        .busy_o(a_busy), .done_o(a_done), .spike_count_o(a_count)
    );

    spiker_result_packer #(.WIDTH(16), .N_SPIKES(40), .IN_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
        .start_i(b_start), .abort_i(b_abort),
        .spike_valid_i(b_valid), .spike_i(b_spike), .spike_ready_o(b_ready),
        .result_d_o(b_d), .result_idx_o(b_idx), .result_de_o(b_de),
        .busy_o(b_busy), .done_o(b_done), .spike_count_o(b_count)
    );

    int total = 0;
    int bad = 0;

    // Strobe/accept recorder, written only by this process.
    logic [31:0] sa_d [0:255];
    int          sa_idx [0:255];
    int          na = 0, na_acc = 0, a_bp_viol = 0;
    logic [15:0] sb_d [0:15];
    int          sb_idx [0:15];
    int          nb = 0;

    always @(negedge clk) begin
        if (a_de) begin
            if (na < 256) begin
                sa_d[na]   = a_d;
                sa_idx[na] = int'(a_idx);
            end
            na = na + 1;
            if (a_ready) a_bp_viol = a_bp_viol + 1;
        end
        if (a_valid && a_ready) na_acc = na_acc + 1;
        if (b_de) begin
            if (nb < 16) begin
                sb_d[nb]   = b_d;
                sb_idx[nb] = int'(b_idx);
            end
            nb = nb + 1;
        end
    end

    logic [7:0] drv_data [0:97];

    typedef struct {
        string       name;
        int          mode;
        bit          fixed;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w24;
        int          cnt;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    // mode 0: all ones, 1: ramp k[7:0], 2: random data with random idle gaps
    task automatic feed_a(input int mode, input int first, input int last);
        for (int k = first; k < last; k++) begin
            logic [7:0] b;
            int waited;
            b = (mode == 0) ? 8'hFF : (mode == 1) ? k[7:0] : 8'($urandom);
            if (mode == 2) begin
                a_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            a_valid = 1'b1;
            a_spike = b;
            waited  = 0;
            forever begin
                @(negedge clk);
                if (a_ready) break;
                waited++;
                if (waited > 20) break;
            end
            if (waited > 20) begin
                total++;
                bad++;
                $display("FAIL a_ready_timeout beat %0d: got no ready expected ready", k);
                a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            a_valid = 1'b0;
            drv_data[k] = b;
            chk($sformatf("a_de_after_beat%0d", k), 64'(a_de), 64'((k % 4 == 3) || (k == 97)));
        end
    endtask

    task automatic check_frame_a(input vec_t v, input int nbase, input int acc_base);
        logic [31:0] exp_w;
        int exp_cnt;
        @(posedge clk); #1;
        chk({v.name, "_done"}, 64'(a_done), 64'(1));
        chk({v.name, "_busy"}, 64'(a_busy), 64'(0));
        exp_cnt = 0;
        for (int k = 0; k < 98; k++) exp_cnt += $countones(drv_data[k]);
        chk({v.name, "_count"}, 64'(a_count), 64'(v.fixed ? v.cnt : exp_cnt));
        chk({v.name, "_accepts"}, 64'(na_acc - acc_base), 64'(98));
        chk({v.name, "_strobes"}, 64'(na - nbase), 64'(25));
        if (na - nbase == 25) begin
            for (int w = 0; w < 25; w++) begin
                exp_w = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * w + j < 98) exp_w[8*j +: 8] = drv_data[4*w + j];
                end
                chk($sformatf("%s_idx%0d", v.name, w), 64'(sa_idx[nbase + w]), 64'(w));
                chk($sformatf("%s_word%0d", v.name, w), 64'(sa_d[nbase + w]), 64'(exp_w));
            end
            if (v.fixed) begin
                chk({v.name, "_tbl_w0"}, 64'(sa_d[nbase]), 64'(v.w0));
                chk({v.name, "_tbl_w1"}, 64'(sa_d[nbase + 1]), 64'(v.w1));
                chk({v.name, "_tbl_w24"}, 64'(sa_d[nbase + 24]), 64'(v.w24));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbase, acc_base;

        vecs[0] = '{"ones", 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 784};
        vecs[1] = '{"ramp", 1, 1'b1, 32'h0302_0100, 32'h0706_0504, 32'h0000_6160, 309};
        vecs[2] = '{"gaps", 2, 1'b0, 32'h0, 32'h0, 32'h0, 0};

        #1;
        chk("rst_ready", 64'(a_ready), 64'(0));
        chk("rst_de", 64'(a_de), 64'(0));
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_done", 64'(a_done), 64'(0));
        chk("rst_d", 64'(a_d), 64'(0));
        chk("rst_idx", 64'(a_idx), 64'(0));
        chk("rst_count", 64'(a_count), 64'(0));

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid held high in IDLE must not be taken.
        acc_base = na_acc;
        a_valid = 1'b1;
        a_spike = 8'hA5;
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_ready", 64'(a_ready), 64'(0));
        end
        a_valid = 1'b0;
        chk("idle_accepts", 64'(na_acc - acc_base), 64'(0));

        for (int v = 0; v < 3; v++) begin
            nbase    = na;
            acc_base = na_acc;
            start_a();
            feed_a(vecs[v].mode, 0, 98);
            check_frame_a(vecs[v], nbase, acc_base);
        end
        chk("bp_no_ready_in_write", 64'(a_bp_viol), 64'(0));

        // Abort after 50 beats, then a clean frame.
        nbase = na;
        start_a();
        feed_a(0, 0, 50);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        chk("abort_busy", 64'(a_busy), 64'(0));
        chk("abort_ready", 64'(a_ready), 64'(0));
        acc_base = na_acc;
        a_valid = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        chk("abort_strobes", 64'(na - nbase), 64'(12));
        chk("abort_accepts", 64'(na_acc - acc_base), 64'(0));
        nbase    = na;
        acc_base = na_acc;
        start_a();
        feed_a(1, 0, 98);
        check_frame_a(vecs[1], nbase, acc_base);

        // Asynchronous reset on beat 2 of word 5.
        nbase = na;
        start_a();
        feed_a(0, 0, 22);
        chk("pre_rst_count", 64'(a_count), 64'(176));
        chk("pre_rst_d", 64'(a_d), 64'(32'hFFFF_FFFF));
        chk("pre_rst_idx", 64'(a_idx), 64'(4));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(a_ready), 64'(0));
        chk("mid_rst_busy", 64'(a_busy), 64'(0));
        chk("mid_rst_de", 64'(a_de), 64'(0));
        chk("mid_rst_d", 64'(a_d), 64'(0));
        chk("mid_rst_idx", 64'(a_idx), 64'(0));
        chk("mid_rst_count", 64'(a_count), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst_strobes", 64'(na - nbase), 64'(5));
        chk("rst_no_word5", 64'(sa_idx[nbase + 4]), 64'(4));

        // Small instance: start ignored in COLLECT, restart from DONE.
        nbase = nb;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            int waited;
            logic [3:0] bv;
            bv = 4'(k + 1);
            b_valid = 1'b1;
            b_spike = bv;
            if (k == 2) b_start = 1'b1;
            waited = 0;
            forever begin
                @(negedge clk);
                if (b_ready) break;
                waited++;
                if (waited > 20) break;
            end
            if (waited > 20) begin
                total++;
                bad++;
                $display("FAIL b_ready_timeout beat %0d: got no ready expected ready", k);
                break;
            end
            @(posedge clk); #1;
            b_valid = 1'b0;
            b_start = 1'b0;
            chk($sformatf("b_de_after_beat%0d", k), 64'(b_de), 64'((k % 4 == 3) || (k == 9)));
        end
        b_valid = 1'b0;
        b_start = 1'b0;
        @(posedge clk); #1;
        chk("b_done", 64'(b_done), 64'(1));
        chk("b_count", 64'(b_count), 64'(17));
        chk("b_strobes", 64'(nb - nbase), 64'(3));
        if (nb - nbase == 3) begin
            chk("b_word0", 64'(sb_d[nbase]), 64'(16'h4321));
            chk("b_word1", 64'(sb_d[nbase + 1]), 64'(16'h8765));
            chk("b_word2", 64'(sb_d[nbase + 2]), 64'(16'h00A9));
            chk("b_idx2", 64'(sb_idx[nbase + 2]), 64'(2));
        end
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        chk("b_restart_done", 64'(b_done), 64'(0));
        chk("b_restart_count", 64'(b_count), 64'(0));
        chk("b_restart_busy", 64'(b_busy), 64'(1));
        b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0;
        chk("b_abort_busy", 64'(b_busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
